// File: rtl/riscv_pkg.sv
// RV32I opcode/funct constants and request-op encoding shared by
// the program writer and the core control decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_ADDI    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        REQ_LW   = 3'd0,
        REQ_SW   = 3'd1,
        REQ_BEQ  = 3'd2,
        REQ_ADD  = 3'd3,
        REQ_SUB  = 3'd4,
        REQ_AND  = 3'd5,
        REQ_OR   = 3'd6,
        REQ_ADDI = 3'd7
    } req_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WRITE,
        S_ERR,
        S_FULL
    } wr_state_e;

    // 13-bit request immediate must sign-extend cleanly from bit 11
    function automatic logic imm_fits12(input logic [12:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/imem_program_writer_if.sv
// Request handshake and instruction-memory write bus of the
// program writer; master issues requests, slave encodes and writes.
interface imem_program_writer_if #(
    parameter int ADDR_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [12:0]       req_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_program_writer_encoder.sv
// Combinational RV32I encoder for the supported subset; flags
// immediates that cannot be represented in the target format.
module instr_encoder
    import riscv_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [12:0] imm_i,
    output logic [31:0] word_o,
    output logic        valid_o
);

    always_comb begin
        word_o  = '0;
        valid_o = 1'b0;
        case (req_op_e'(op_i))
            REQ_LW: begin
                word_o  = {imm_i[11:0], rs1_i, F3_LW, rd_i, OP_LOAD};
                valid_o = imm_fits12(imm_i);
            end
            REQ_SW: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, F3_SW,
                           imm_i[4:0], OP_STORE};
                valid_o = imm_fits12(imm_i);
            end
            REQ_BEQ: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                           imm_i[4:1], imm_i[11], OP_BRANCH};
                valid_o = ~imm_i[0];
            end
            REQ_ADD: begin
                word_o  = {F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OP_RTYPE};
                valid_o = 1'b1;
            end
            REQ_SUB: begin
                word_o  = {F7_SUB, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OP_RTYPE};
                valid_o = 1'b1;
            end
            REQ_AND: begin
                word_o  = {F7_BASE, rs2_i, rs1_i, F3_AND, rd_i, OP_RTYPE};
                valid_o = 1'b1;
            end
            REQ_OR: begin
                word_o  = {F7_BASE, rs2_i, rs1_i, F3_OR, rd_i, OP_RTYPE};
                valid_o = 1'b1;
            end
            REQ_ADDI: begin
                word_o  = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OP_IMM};
                valid_o = imm_fits12(imm_i);
            end
            default: begin
                word_o  = '0;
                valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imem_program_writer.sv
// Accepts symbolic instruction requests, encodes them and writes the
// words to consecutive instruction-memory addresses until full.
module imem_program_writer
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    imem_program_writer_if.slave bus,
    output logic                 full,
    output logic                 err,
    output logic [ADDR_W:0]      wr_count
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    wr_state_e       state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [12:0]     imm_q, imm_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     enc_word;
    logic            enc_valid;

    instr_encoder u_enc (
        .op_i    (op_q),
        .rd_i    (rd_q),
        .rs1_i   (rs1_q),
        .rs2_i   (rs2_q),
        .imm_i   (imm_q),
        .word_o  (enc_word),
        .valid_o (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        rd_d           = rd_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        imm_d          = imm_q;
        word_d         = word_q;
        bus.req_ready  = 1'b0;
        bus.imem_we    = 1'b0;
        bus.imem_addr  = '0;
        bus.imem_wdata = '0;
        err            = 1'b0;
        full           = 1'b0;
        // clear wins over everything and also kills a write in flight
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        op_d    = bus.req_op;
                        rd_d    = bus.req_rd;
                        rs1_d   = bus.req_rs1;
                        rs2_d   = bus.req_rs2;
                        imm_d   = bus.req_imm;
                        state_d = S_ENC;
                    end
                end
                S_ENC: begin
                    word_d  = enc_word;
                    state_d = enc_valid ? S_WRITE : S_ERR;
                end
                S_WRITE: begin
                    bus.imem_we    = 1'b1;
                    bus.imem_addr  = cnt_q[ADDR_W-1:0];
                    bus.imem_wdata = word_q;
                    cnt_d          = cnt_q + 1'b1;
                    state_d        = (cnt_d == DEPTH_W) ? S_FULL : S_IDLE;
                end
                S_ERR: begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
                S_FULL: begin
                    full = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign wr_count = cnt_q;

endmodule

// File: tb/tb_imem_program_writer.sv
// Directed bench: scoreboard of expected writes checked by a monitor.
module tb_imem_program_writer;
    import riscv_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic            full;
    logic            err;
    logic [ADDR_W:0] wr_count;

    imem_program_writer_if #(.ADDR_W(ADDR_W)) bus ();

    imem_program_writer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus.slave),
        .full     (full),
        .err      (err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   writes = 0;
    int   pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            exp_t e;
            writes++;
            if (sb.size() == 0) begin
                chk("unexpected_write", bus.imem_we, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", bus.imem_addr, e.addr);
                chk("wr_data", bus.imem_wdata, e.data);
                chk("wr_latency", cyc, e.c);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm);
        bus.req_op    = op;
        bus.req_rd    = rd;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_imm   = imm;
        bus.req_valid = 1'b1;
    endtask

    task automatic accept(output int acyc);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                got = 1;
            end else begin
                @(posedge clk);
            end
        end
        chk("accept_timeout", got, 1);
        bus.req_valid = 1'b0;
        acyc = cyc;
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d,
                        input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.c    = c;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic post_accept(input bit is_err);
        @(negedge clk);
        chk("busy1_ready", bus.req_ready, 0);
        @(negedge clk);
        chk("busy2_ready", bus.req_ready, 0);
        if (is_err) begin
            chk("err_pulse", err, 1);
            chk("err_no_we", bus.imem_we, 0);
        end else begin
            chk("we_pulse", bus.imem_we, 1);
            chk("no_err", err, 0);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [12:0] imm, input bit is_err,
                        input logic [7:0] a, input logic [31:0] d);
        int ac;
        drive(op, rd, rs1, rs2, imm);
        accept(ac);
        if (!is_err) push(a, d, ac + 1);
        post_accept(is_err);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clear_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int ac;
        bit drained;
        reset         = 1'b1;
        clear         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rd    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_imm   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_we", bus.imem_we, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_count", wr_count, 0);
        reset = 1'b0;

        send(REQ_ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 0, 8'd0, 32'h00500093);
        @(negedge clk);
        chk("count_after_addi", wr_count, 1);
        chk("idle_ready", bus.req_ready, 1);

        send(REQ_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 0, 8'd1, 32'h002081B3);
        send(REQ_SUB, 5'd3, 5'd1, 5'd2, 13'd0, 0, 8'd2, 32'h402081B3);
        @(negedge clk);
        chk("count_3", wr_count, 3);
        do_clear();
        @(negedge clk);
        chk("count_cleared", wr_count, 0);

        send(REQ_SW, 5'd0, 5'd1, 5'd2, 13'd8, 0, 8'd0, 32'h0020A423);
        send(REQ_LW, 5'd5, 5'd1, 5'd0, 13'h1FFC, 0, 8'd1, 32'hFFC0A283);
        send(REQ_BEQ, 5'd0, 5'd1, 5'd2, 13'h1FF8, 0, 8'd2, 32'hFE208CE3);

        send(REQ_BEQ, 5'd0, 5'd1, 5'd2, 13'd3, 1, 8'd0, 32'd0);
        @(negedge clk);
        chk("count_after_err1", wr_count, 3);
        send(REQ_ADDI, 5'd1, 5'd0, 5'd0, 13'h0800, 1, 8'd0, 32'd0);
        @(negedge clk);
        chk("count_after_err2", wr_count, 3);

        send(REQ_ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 0, 8'd3, 32'h00500093);
        @(negedge clk);
        chk("full_set", full, 1);
        chk("full_ready", bus.req_ready, 0);
        chk("full_count", wr_count, 4);

        drive(REQ_OR, 5'd4, 5'd1, 5'd2, 13'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_hold_ready", bus.req_ready, 0);
            chk("full_hold_full", full, 1);
        end
        do_clear();
        @(negedge clk);
        chk("full_cleared", full, 0);
        chk("full_clr_count", wr_count, 0);
        accept(ac);
        push(8'd0, 32'h0020E233, ac + 1);
        post_accept(0);

        drive(REQ_AND, 5'd5, 5'd3, 5'd4, 13'd0);
        accept(ac);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("enc_clr_count", wr_count, 0);
        chk("enc_clr_ready", bus.req_ready, 1);
        send(REQ_AND, 5'd5, 5'd3, 5'd4, 13'd0, 0, 8'd0, 32'h0041F2B3);

        drive(REQ_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
        accept(ac);
        @(posedge clk);
        #1;
        clear = 1'b1;
        #1;
        chk("wr_clr_we", bus.imem_we, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("wr_clr_count", wr_count, 0);
        send(REQ_SUB, 5'd3, 5'd1, 5'd2, 13'd0, 0, 8'd0, 32'h402081B3);

        @(negedge clk);
        drive(REQ_ADDI, 5'd1, 5'd0, 5'd0, 13'd5);
        clear = 1'b1;
        #1;
        chk("vclr_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        clear         = 1'b0;
        @(negedge clk);
        chk("vclr_not_taken", bus.req_ready, 1);
        chk("vclr_count", wr_count, 0);
        repeat (3) @(negedge clk);
        send(REQ_OR, 5'd4, 5'd1, 5'd2, 13'd0, 0, 8'd0, 32'h0020E233);

        drained = 0;
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            if (sb.size() == 0) drained = 1;
        end
        chk("sb_drain", sb.size(), 0);
        chk("write_total", writes, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
